// File: rtl/bpred_pkg.sv
// Shared widths, table entry / update payload types and 2-bit counter helpers
// for the bpred_btb branch predictor.
package bpred_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned MACHINE_WIDTH = 4;
  localparam int unsigned BTB_DEPTH     = 64;
  localparam int unsigned BHT_DEPTH     = 512;
  localparam int unsigned TAG_WIDTH     = 10;
  localparam int unsigned GHR_WIDTH     = 8;
  localparam int unsigned IB            = $clog2(BTB_DEPTH);
  localparam int unsigned HB            = $clog2(BHT_DEPTH);
  localparam int unsigned SLOT_W        = $clog2(MACHINE_WIDTH);

  // Weakly not-taken
  localparam logic [1:0] CTR_RESET = 2'b01;

  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
    logic [XLEN-1:0]      target;
  } btb_entry_t;

  typedef struct packed {
    logic            valid;
    logic            taken;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } bpred_upd_t;

  // Saturating increment, never wraps past 3
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  // Saturating decrement, never wraps below 0
  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/bpred_bht.sv
// 2-bit saturating counter table: MACHINE_WIDTH combinational read ports and
// one read-modify-write update port.
module bpred_bht
  import bpred_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [MACHINE_WIDTH-1:0][HB-1:0]  i_rd_idx,
  output logic [MACHINE_WIDTH-1:0][1:0]     o_rd_ctr,
  input  logic                              i_upd_valid,
  input  logic [HB-1:0]                     i_upd_idx,
  input  logic                              i_upd_taken
);

  logic [1:0] r_ctr [BHT_DEPTH];
  logic [1:0] w_upd_cur;

  // Lookup ports return the pre-write value when colliding with an update
  always_comb begin
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      o_rd_ctr[i] = r_ctr[i_rd_idx[i]];
    end
  end

  assign w_upd_cur = r_ctr[i_upd_idx];

  // Counter array with saturating training
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        r_ctr[i] <= CTR_RESET;
      end
    end else if (i_upd_valid) begin
      r_ctr[i_upd_idx] <= i_upd_taken ? ctr_inc(w_upd_cur) : ctr_dec(w_upd_cur);
    end
  end

endmodule

// File: rtl/bpred_btb.sv
// Direct-mapped BTB plus 2-bit BHT predictor: zero-cycle lookup of
// MACHINE_WIDTH sequential PCs, trained through a one-deep update register.
// Optional global history indexing is enabled with macro BPRED_GHR_EN.
module bpred_btb
  import bpred_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            fetch_valid,
  input  logic [XLEN-1:0]                 fetch_pc,
  output logic [MACHINE_WIDTH-1:0]        pred_taken,
  output logic [XLEN*MACHINE_WIDTH-1:0]   pred_target,
  output logic                            redirect,
  output logic [XLEN-1:0]                 redirect_pc,
  output logic [SLOT_W-1:0]               redirect_slot,
  input  logic                            upd_valid,
  input  logic [XLEN-1:0]                 upd_pc,
  input  logic                            upd_taken,
  input  logic [XLEN-1:0]                 upd_target
);

  bpred_upd_t                          r_upd_q;
  btb_entry_t                          r_btb [BTB_DEPTH];
  logic [MACHINE_WIDTH-1:0][XLEN-1:0]  w_slot_pc;
  logic [MACHINE_WIDTH-1:0][XLEN-1:0]  w_slot_tgt;
  logic [MACHINE_WIDTH-1:0][HB-1:0]    w_bht_rd_idx;
  logic [MACHINE_WIDTH-1:0][1:0]       w_bht_rd_ctr;
  logic [MACHINE_WIDTH-1:0]            w_taken;
  logic [HB-1:0]                       w_hist_mask;
  logic [HB-1:0]                       w_upd_bht_idx;
  logic [IB-1:0]                       w_upd_btb_idx;
  logic                                w_unused;

`ifdef BPRED_GHR_EN
  logic [GHR_WIDTH-1:0] r_ghr;

  // Committed history: shifts when the registered update is written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr <= '0;
    end else if (r_upd_q.valid) begin
      r_ghr <= {r_ghr[GHR_WIDTH-2:0], r_upd_q.taken};
    end
  end

  assign w_hist_mask = HB'(r_ghr);
`else
  assign w_hist_mask = '0;
`endif

  // Slot PCs and BHT read indices
  always_comb begin
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      w_slot_pc[i]    = fetch_pc + XLEN'(4 * i);
      w_bht_rd_idx[i] = w_slot_pc[i][2+:HB] ^ w_hist_mask;
    end
  end

  // Per-slot tag compare and direction
  always_comb begin
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      btb_entry_t v_ent;
      logic       v_hit;
      v_ent         = r_btb[w_slot_pc[i][2+:IB]];
      v_hit         = fetch_valid & v_ent.valid & (v_ent.tag == w_slot_pc[i][2+IB+:TAG_WIDTH]);
      w_taken[i]    = v_hit & w_bht_rd_ctr[i][1];
      w_slot_tgt[i] = w_taken[i] ? v_ent.target : '0;
    end
  end

  assign pred_taken  = w_taken;
  assign pred_target = w_slot_tgt;

  // Lowest taken slot wins the redirect
  always_comb begin
    redirect      = |w_taken;
    redirect_pc   = '0;
    redirect_slot = '0;
    for (int i = MACHINE_WIDTH - 1; i >= 0; i--) begin
      if (w_taken[i]) begin
        redirect_pc   = w_slot_tgt[i];
        redirect_slot = SLOT_W'(i);
      end
    end
  end

  // One-deep update register, never discarded except by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_upd_q <= '0;
    end else begin
      r_upd_q.valid  <= upd_valid;
      r_upd_q.taken  <= upd_taken;
      r_upd_q.pc     <= upd_pc;
      r_upd_q.target <= upd_target;
    end
  end

  assign w_upd_btb_idx = r_upd_q.pc[2+:IB];
  assign w_upd_bht_idx = r_upd_q.pc[2+:HB] ^ w_hist_mask;

  // BTB allocate/overwrite on taken resolution only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        r_btb[i] <= '0;
      end
    end else if (r_upd_q.valid && r_upd_q.taken) begin
      r_btb[w_upd_btb_idx] <= '{valid:  1'b1,
                                tag:    r_upd_q.pc[2+IB+:TAG_WIDTH],
                                target: r_upd_q.target};
    end
  end

  bpred_bht u_bht (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_idx    (w_bht_rd_idx),
    .o_rd_ctr    (w_bht_rd_ctr),
    .i_upd_valid (r_upd_q.valid),
    .i_upd_idx   (w_upd_bht_idx),
    .i_upd_taken (r_upd_q.taken)
  );

  // PC alignment/upper bits and counter LSBs are intentionally not consumed
  assign w_unused = ^{r_upd_q.pc, w_slot_pc, w_bht_rd_ctr};

endmodule

// File: tb/tb_bpred_btb.sv
// Randomized and directed bench for bpred_btb against a table-level model.
module tb_bpred_btb;
  import bpred_pkg::*;

  localparam int unsigned CW = XLEN * MACHINE_WIDTH;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          fetch_valid;
  logic [XLEN-1:0]               fetch_pc;
  logic [MACHINE_WIDTH-1:0]      pred_taken;
  logic [CW-1:0]                 pred_target;
  logic                          redirect;
  logic [XLEN-1:0]               redirect_pc;
  logic [SLOT_W-1:0]             redirect_slot;
  logic                          upd_valid;
  logic [XLEN-1:0]               upd_pc;
  logic                          upd_taken;
  logic [XLEN-1:0]               upd_target;

  bpred_btb dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_valid   (fetch_valid),
    .fetch_pc      (fetch_pc),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .redirect_slot (redirect_slot),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference state: plain arrays indexed by integer PC arithmetic
  bit              m_valid [BTB_DEPTH];
  int unsigned     m_tag   [BTB_DEPTH];
  logic [XLEN-1:0] m_tgt   [BTB_DEPTH];
  int              m_ctr   [BHT_DEPTH];
  int unsigned     m_ghr;
  bit              p_valid;
  bit              p_taken;
  logic [XLEN-1:0] p_pc;
  logic [XLEN-1:0] p_tgt;

  function automatic int unsigned btb_idx(input logic [XLEN-1:0] pc);
    return (pc / 4) % BTB_DEPTH;
  endfunction

  function automatic int unsigned btb_tag(input logic [XLEN-1:0] pc);
    return (pc / (4 * BTB_DEPTH)) % (2 ** TAG_WIDTH);
  endfunction

  function automatic int unsigned bht_idx(input logic [XLEN-1:0] pc);
    return ((pc / 4) % BHT_DEPTH) ^ m_ghr;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BTB_DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = '0;
    end
    for (int i = 0; i < BHT_DEPTH; i++) m_ctr[i] = 1;
    m_ghr   = 0;
    p_valid = 1'b0;
  endtask

  // Called at each rising edge: retire pending update, then latch the inputs
  task automatic model_commit();
    if (p_valid) begin
      int unsigned h;
      int unsigned b;
      h = bht_idx(p_pc);
      b = btb_idx(p_pc);
      m_ctr[h] = p_taken ? ((m_ctr[h] + 1 > 3) ? 3 : m_ctr[h] + 1)
                         : ((m_ctr[h] - 1 < 0) ? 0 : m_ctr[h] - 1);
      if (p_taken) begin
        m_valid[b] = 1'b1;
        m_tag[b]   = btb_tag(p_pc);
        m_tgt[b]   = p_tgt;
      end
`ifdef BPRED_GHR_EN
      m_ghr = ((m_ghr * 2) + (p_taken ? 1 : 0)) % (2 ** GHR_WIDTH);
`endif
    end
    p_valid = upd_valid;
    p_taken = upd_taken;
    p_pc    = upd_pc;
    p_tgt   = upd_target;
  endtask

  task automatic check_lookup(input string tag);
    logic [MACHINE_WIDTH-1:0] e_taken;
    logic [CW-1:0]            e_tgt;
    logic                     e_red;
    logic [XLEN-1:0]          e_rpc;
    int unsigned              e_slot;
    e_taken = '0;
    e_tgt   = '0;
    e_red   = 1'b0;
    e_rpc   = '0;
    e_slot  = 0;
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      logic [XLEN-1:0] pc;
      int unsigned     b;
      pc = fetch_pc + 4 * i;
      b  = btb_idx(pc);
      if (fetch_valid && m_valid[b] && m_tag[b] == btb_tag(pc) && m_ctr[bht_idx(pc)] >= 2) begin
        e_taken[i]           = 1'b1;
        e_tgt[i*XLEN+:XLEN]  = m_tgt[b];
        if (!e_red) begin
          e_red  = 1'b1;
          e_rpc  = m_tgt[b];
          e_slot = i;
        end
      end
    end
    check({tag, ".taken"},  pred_taken,    e_taken);
    check({tag, ".target"}, pred_target,   e_tgt);
    check({tag, ".redir"},  redirect,      e_red);
    check({tag, ".rpc"},    redirect_pc,   e_rpc);
    check({tag, ".rslot"},  redirect_slot, e_slot);
  endtask

  task automatic step(input logic fv, input logic [XLEN-1:0] fpc, input logic uv,
                      input logic [XLEN-1:0] upc, input logic ut, input logic [XLEN-1:0] utgt,
                      input string tag);
    @(posedge clk);
    model_commit();
    #1;
    fetch_valid = fv;
    fetch_pc    = fpc;
    upd_valid   = uv;
    upd_pc      = upc;
    upd_taken   = ut;
    upd_target  = utgt;
    @(negedge clk);
    check_lookup(tag);
  endtask

  task automatic idle(input logic [XLEN-1:0] fpc, input string tag);
    step(1'b1, fpc, 1'b0, '0, 1'b0, '0, tag);
  endtask

  logic [XLEN-1:0] pool [16];

  initial begin
    rst_n       = 1'b0;
    fetch_valid = 1'b1;
    fetch_pc    = 32'h1000;
    upd_valid   = 1'b0;
    upd_pc      = '0;
    upd_taken   = 1'b0;
    upd_target  = '0;
    model_reset();
    #12;
    check_lookup("rst_held");
    check("rst_taken_zero", pred_taken, '0);
    rst_n = 1'b1;
    #2;
    check_lookup("rst_rel");
    check("rst_redirect_zero", redirect, 1'b0);

    // Single taken training of slot 2 branch
    step(1'b1, 32'h1000, 1'b1, 32'h1008, 1'b1, 32'h2000, "a_upd");
    idle(32'h1000, "a_wait");
    idle(32'h1000, "a_hit");
`ifndef BPRED_GHR_EN
    check("a_ptaken", pred_taken, 4'b0100);
    check("a_rpc", redirect_pc, 32'h2000);
    check("a_rslot", redirect_slot, 2);
`endif

    // Two back-to-back not-taken updates
    step(1'b1, 32'h1000, 1'b1, 32'h1008, 1'b0, '0, "b_n1");
    step(1'b1, 32'h1000, 1'b1, 32'h1008, 1'b0, '0, "b_n2");
    idle(32'h1000, "b_w1");
    idle(32'h1000, "b_w2");
`ifndef BPRED_GHR_EN
    check("b_ptaken", pred_taken, '0);
    check("b_redir", redirect, 1'b0);
`endif

    // Five taken then one not-taken: saturation, no wrap
    for (int k = 0; k < 5; k++) step(1'b1, 32'h1000, 1'b1, 32'h1008, 1'b1, 32'h2000, "c_t");
    step(1'b1, 32'h1000, 1'b1, 32'h1008, 1'b0, '0, "c_n");
    idle(32'h1000, "c_w1");
    idle(32'h1000, "c_w2");
`ifndef BPRED_GHR_EN
    check("c_ptaken_sat", pred_taken, 4'b0100);
`endif

    // Aliasing: same BTB index, different tag
    step(1'b1, 32'h1000, 1'b1, 32'h1008 + BTB_DEPTH * 4, 1'b1, 32'h3000, "d_upd");
    idle(32'h1000, "d_w1");
    idle(32'h1000, "d_old");
`ifndef BPRED_GHR_EN
    check("d_old_miss", pred_taken, '0);
`endif
    idle(32'h1000 + BTB_DEPTH * 4, "d_new");
`ifndef BPRED_GHR_EN
    check("d_new_hit", pred_taken, 4'b0100);
    check("d_new_rpc", redirect_pc, 32'h3000);
`endif

    // Slots 1 and 3 taken: priority to slot 1
    step(1'b1, 32'h4000, 1'b1, 32'h4004, 1'b1, 32'h5000, "e_u1");
    step(1'b1, 32'h4000, 1'b1, 32'h400C, 1'b1, 32'h6000, "e_u3");
    idle(32'h4000, "e_w1");
    idle(32'h4000, "e_pick");
`ifndef BPRED_GHR_EN
    check("e_ptaken", pred_taken, 4'b1010);
    check("e_rslot", redirect_slot, 1);
    check("e_rpc", redirect_pc, 32'h5000);
    check("e_targets", pred_target, {32'h6000, 32'h0, 32'h5000, 32'h0});
`endif

    // Alternating T,N history on one branch
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 32'h9000, 1'b1, 32'h9000, k[0] == 1'b0, 32'hA000, "g_alt");
    end

    // Randomized traffic over a small PC pool to provoke hits and aliasing
    for (int k = 0; k < 16; k++) pool[k] = 32'h8000 + 4 * $urandom_range(0, 255);
    for (int k = 0; k < 400; k++) begin
      logic [XLEN-1:0] fpc;
      logic [XLEN-1:0] upc;
      fpc = pool[$urandom_range(0, 15)] - 4 * $urandom_range(0, MACHINE_WIDTH - 1);
      upc = pool[$urandom_range(0, 15)];
      step($urandom_range(0, 9) != 0, fpc, $urandom_range(0, 3) != 0, upc,
           $urandom_range(0, 9) < 6, {$urandom_range(0, 16'hFFFF), 2'b00}, "rnd");
    end

    // Asynchronous reset mid-operation with an update in flight
    step(1'b1, pool[0], 1'b1, pool[0], 1'b1, 32'hBEEC, "r_pre");
    @(posedge clk);
    model_commit();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_lookup("r_mid");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) idle(pool[k], "r_post");
    for (int k = 0; k < 60; k++) begin
      step(1'b1, pool[$urandom_range(0, 15)], $urandom_range(0, 1) == 1, pool[$urandom_range(0, 15)],
           $urandom_range(0, 3) != 0, {$urandom_range(0, 16'hFFFF), 2'b00}, "r_rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
